// File: rtl/pipeline_perf_counters_pkg.sv
// Shared constants for the pipeline performance counter block: overflow
// policy selectors and the readout-select encoding of the cycle-count entry.
package perf_pkg;

  localparam int PERF_WRAP = 0;
  localparam int PERF_SAT  = 1;

  // The cycle counter sits just above the last event channel in the bank.
  function automatic int cycleSel(input int numCh);
    return numCh;
  endfunction

endpackage

// File: rtl/pipeline_perf_counters_cell.sv
// One live counter with a wrap/saturate overflow policy and a sticky
// overflow flag; Next exposes the post-edge value for snapshot capture.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SAT   = PERF_WRAP
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Inc,
  input  logic             Clear,
  output logic [CNT_W-1:0] Count,
  output logic [CNT_W-1:0] Next,
  output logic             Ovf
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  logic atMax;

  assign atMax = (Count == MAX_VAL);

  // Next is the value this counter takes on the coming edge, ignoring Clear,
  // because a clearing edge never captures a snapshot anyway.
  always_comb begin
    Next = Count;
    if (Inc) begin
      if (!atMax)
        Next = Count + CNT_W'(1);
      else if (SAT == PERF_SAT)
        Next = MAX_VAL;
      else
        Next = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Count <= '0;
      Ovf   <= 1'b0;
    end else if (Clear) begin
      Count <= '0;
      Ovf   <= 1'b0;
    end else begin
      Count <= Next;
      if (Inc && atMax)
        Ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_perf_counters.sv
// Cycle and per-channel event counters with a periodic snapshot bank and a
// registered readout mux for the display/debug path.
module pipeline_perf_counters
  import perf_pkg::*;
#(
  parameter int              NUM_CH = 4,
  parameter int              CNT_W  = 32,
  parameter longint unsigned PERIOD = 1000,
  parameter int              SAT    = PERF_WRAP,
  localparam int             SEL_W  = $clog2(NUM_CH + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              En,
  input  logic [NUM_CH-1:0] Event,
  input  logic              Clear,
  input  logic [SEL_W-1:0]  RdSel,
  output logic [CNT_W-1:0]  RdData,
  output logic              SnapValid,
  output logic [CNT_W-1:0]  CycleCnt,
  output logic [NUM_CH:0]   Overflow
);

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [SEL_W-1:0] CYCLE_SEL   = SEL_W'(cycleSel(NUM_CH));

  logic [NUM_CH:0]            incVec;
  logic [NUM_CH:0]            ovfVec;
  logic [NUM_CH:0][CNT_W-1:0] countVec;
  logic [NUM_CH:0][CNT_W-1:0] nextVec;
  logic [CNT_W-1:0]           periodCnt;
  logic [CNT_W-1:0]           snapBank [NUM_CH+1];
  logic                       periodLast;
  logic                       snapCycle;

  // Entry NUM_CH is the cycle counter, which counts every enabled cycle.
  for (genvar i = 0; i <= NUM_CH; i++) begin : gCell
    if (i < NUM_CH) begin : gEvent
      assign incVec[i] = En & Event[i];
    end else begin : gCycle
      assign incVec[i] = En;
    end

    perf_counter_cell #(
      .CNT_W (CNT_W),
      .SAT   (SAT)
    ) uCell (
      .Clock (Clock),
      .Reset (Reset),
      .Inc   (incVec[i]),
      .Clear (Clear),
      .Count (countVec[i]),
      .Next  (nextVec[i]),
      .Ovf   (ovfVec[i])
    );
  end

  assign CycleCnt   = countVec[NUM_CH];
  assign Overflow   = ovfVec;
  assign periodLast = (periodCnt == PERIOD_LAST);
  assign snapCycle  = En & periodLast & ~Clear;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      periodCnt <= '0;
    else if (Clear)
      periodCnt <= '0;
    else if (En)
      periodCnt <= periodLast ? '0 : periodCnt + CNT_W'(1);
  end

  // The bank captures post-increment values so a snapshot includes its own cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i <= NUM_CH; i++)
        snapBank[i] <= '0;
      SnapValid <= 1'b0;
    end else begin
      if (snapCycle) begin
        for (int i = 0; i <= NUM_CH; i++)
          snapBank[i] <= nextVec[i];
      end
      SnapValid <= snapCycle;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      RdData <= '0;
    else if (RdSel <= CYCLE_SEL)
      RdData <= snapBank[RdSel];
    else
      RdData <= '0;
  end

endmodule

// File: tb/tb_pipeline_perf_counters.sv
// Self-checking bench: wrap and saturate instances share stimulus and are
// compared every cycle against an increment-count model of the counters.
module tb_pipeline_perf_counters;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int PERIOD = 10;
  localparam int SEL_W  = 3;
  localparam int MAXV   = 255;

  logic              Clock = 1'b0;
  logic              rstN;
  logic              En;
  logic              Clear;
  logic [NUM_CH-1:0] Event;
  logic [SEL_W-1:0]  RdSel;

  logic [CNT_W-1:0] rdDataW, rdDataS, cycleCntW, cycleCntS;
  logic             snapValidW, snapValidS;
  logic [NUM_CH:0]  overflowW, overflowS;

  int errors = 0;
  int checks = 0;

  // Model state: raw increment totals since the last clear, which map to
  // wrapped or saturated counter values by plain arithmetic.
  int incs [NUM_CH+1] = '{default: 0};
  int enCycles = 0;
  int snapW [NUM_CH+1] = '{default: 0};
  int snapS [NUM_CH+1] = '{default: 0};
  int expRdW = 0;
  int expRdS = 0;
  bit expSv  = 1'b0;

  pipeline_perf_counters #(
    .NUM_CH (NUM_CH), .CNT_W (CNT_W), .PERIOD (PERIOD), .SAT (0)
  ) dutW (
    .Clock (Clock), .Reset (rstN), .En (En), .Event (Event), .Clear (Clear),
    .RdSel (RdSel), .RdData (rdDataW), .SnapValid (snapValidW),
    .CycleCnt (cycleCntW), .Overflow (overflowW)
  );

  pipeline_perf_counters #(
    .NUM_CH (NUM_CH), .CNT_W (CNT_W), .PERIOD (PERIOD), .SAT (1)
  ) dutS (
    .Clock (Clock), .Reset (rstN), .En (En), .Event (Event), .Clear (Clear),
    .RdSel (RdSel), .RdData (rdDataS), .SnapValid (snapValidS),
    .CycleCnt (cycleCntS), .Overflow (overflowS)
  );

  always #5 Clock = ~Clock;

  function automatic int wrapOf(input int n);
    return n % (MAXV + 1);
  endfunction

  function automatic int satOf(input int n);
    return (n > MAXV) ? MAXV : n;
  endfunction

  function automatic logic [NUM_CH:0] ovfOf();
    logic [NUM_CH:0] v;
    for (int i = 0; i <= NUM_CH; i++)
      v[i] = (incs[i] > MAXV);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model update on each clock edge, or immediately on reset.
  initial begin
    forever begin
      @(posedge Clock or negedge rstN);
      if (!rstN) begin
        for (int i = 0; i <= NUM_CH; i++) begin
          incs[i] = 0; snapW[i] = 0; snapS[i] = 0;
        end
        enCycles = 0; expRdW = 0; expRdS = 0; expSv = 1'b0;
      end else begin
        expRdW = (int'(RdSel) <= NUM_CH) ? snapW[RdSel] : 0;
        expRdS = (int'(RdSel) <= NUM_CH) ? snapS[RdSel] : 0;
        if (Clear) begin
          for (int i = 0; i <= NUM_CH; i++) incs[i] = 0;
          enCycles = 0;
          expSv = 1'b0;
        end else if (En) begin
          for (int i = 0; i < NUM_CH; i++) if (Event[i]) incs[i]++;
          incs[NUM_CH]++;
          enCycles++;
          expSv = (enCycles % PERIOD == 0);
          if (expSv) begin
            for (int i = 0; i <= NUM_CH; i++) begin
              snapW[i] = wrapOf(incs[i]);
              snapS[i] = satOf(incs[i]);
            end
          end
        end else begin
          expSv = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge Clock);
      checkOutput("cycleW", cycleCntW, wrapOf(incs[NUM_CH]));
      checkOutput("cycleS", cycleCntS, satOf(incs[NUM_CH]));
      checkOutput("ovfW", overflowW, ovfOf());
      checkOutput("ovfS", overflowS, ovfOf());
      checkOutput("svW", snapValidW, expSv);
      checkOutput("svS", snapValidS, expSv);
      checkOutput("rdW", rdDataW, expRdW);
      checkOutput("rdS", rdDataS, expRdS);
    end
  end

  task automatic applyStimulus(input bit en, input logic [NUM_CH-1:0] ev,
                               input bit clr, input logic [SEL_W-1:0] sel, input int cycles);
    En = en; Event = ev; Clear = clr; RdSel = sel;
    repeat (cycles) @(negedge Clock);
  endtask

  initial begin
    rstN = 1'b0; En = 1'b0; Clear = 1'b0; Event = '0; RdSel = '0;
    repeat (3) @(negedge Clock);
    checkOutput("resetCycle", cycleCntW, 0);
    checkOutput("resetRd", rdDataW, 0);

    // First period straight out of reset.
    rstN = 1'b1;
    applyStimulus(1'b1, 4'b0001, 1'b0, 3'd0, 9);
    checkOutput("noSvEarly", snapValidW, 0);
    @(negedge Clock);
    checkOutput("svFirst", snapValidW, 1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1);
    checkOutput("rdCh0", rdDataW, 10);
    applyStimulus(1'b0, 4'b0000, 1'b0, 3'd4, 1);
    checkOutput("rdCycle", rdDataW, 10);
    applyStimulus(1'b0, 4'b0000, 1'b0, 3'd1, 1);
    checkOutput("rdCh1", rdDataW, 0);

    // Enable gating: half the cycles enabled.
    applyStimulus(1'b0, 4'b0000, 1'b1, 3'd1, 1);
    for (int i = 0; i < 20; i++)
      applyStimulus(i % 2 == 0, 4'b1111, 1'b0, 3'd1, 1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 3'd3, 1);
    checkOutput("gateCh3", rdDataW, 10);

    // Overflow: 257 events on channel 2, snapshot at 260 enabled cycles.
    applyStimulus(1'b0, 4'b0000, 1'b1, 3'd2, 1);
    applyStimulus(1'b1, 4'b0100, 1'b0, 3'd2, 257);
    applyStimulus(1'b1, 4'b0000, 1'b0, 3'd2, 3);
    checkOutput("svOvf", snapValidW, 1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 3'd2, 1);
    checkOutput("wrapCh2", rdDataW, 1);
    checkOutput("satCh2", rdDataS, 255);
    checkOutput("ovfW2", overflowW[2], 1);
    checkOutput("ovfS2", overflowS[2], 1);
    checkOutput("satCycle", cycleCntS, 255);
    applyStimulus(1'b0, 4'b0000, 1'b1, 3'd2, 1);
    checkOutput("ovfCleared", overflowW, 0);

    // Clear colliding with the snapshot cycle.
    applyStimulus(1'b1, 4'b0000, 1'b0, 3'd2, 9);
    applyStimulus(1'b1, 4'b0000, 1'b1, 3'd2, 1);
    checkOutput("svSuppressed", snapValidW, 0);
    checkOutput("rdRetained", rdDataW, 1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 3'd2, 10);
    checkOutput("svAfterClear", snapValidW, 1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 3'd2, 1);
    checkOutput("rdNewSnap", rdDataW, 0);

    // Asynchronous reset in the middle of a period.
    applyStimulus(1'b0, 4'b0000, 1'b1, 3'd4, 1);
    applyStimulus(1'b1, 4'b1010, 1'b0, 3'd4, 5);
    #2 rstN = 1'b0;
    #1;
    checkOutput("asyncCycle", cycleCntW, 0);
    checkOutput("asyncOvf", overflowS, 0);
    checkOutput("asyncRd", rdDataW, 0);
    checkOutput("asyncSv", snapValidW, 0);
    @(negedge Clock);
    rstN = 1'b1;
    applyStimulus(1'b1, 4'b1010, 1'b0, 3'd4, 3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 3) != 0, NUM_CH'($urandom),
                    $urandom_range(0, 49) == 0, SEL_W'($urandom_range(0, 7)), 1);

    applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_perf_counters.md
# pipeline_perf_counters

Parametrised successor to the CPU top's single 64-bit cycle counter and its "sample every 1000 cycles" register. It counts clock cycles plus NUM_CH independent pipeline event streams (e.g. stalls, flushes, retired instructions, branches taken). Every PERIOD counted cycles it snapshots all counts into a readout bank, with a selectable wrap or saturate overflow policy. It sits beside the pipelined CPU top, clocked by the divided CPU clock, and feeds the display or debug path.

## Interface
Parameters:
- NUM_CH, 4: number of event channels (1..16).
- CNT_W, 32: width of every counter and snapshot (8..64).
- PERIOD, 1000: counted cycles between snapshots (2..2^CNT_W-1).
- SAT, 0: 0 = counters wrap to 0 on overflow; 1 = counters saturate at 2^CNT_W-1.

Ports:
- Clock, in, 1: single clock; all state is on its rising edge.
- Reset, in, 1: asynchronous, active-low reset.
- En, in, 1: count enable; low freezes the cycle, period and event counters.
- Event, in, NUM_CH: per-channel increment request, sampled each cycle.
- Clear, in, 1: synchronous clear of the live counters.
- RdSel, in, $clog2(NUM_CH+1): snapshot select; 0..NUM_CH-1 selects a channel, NUM_CH selects the cycle count.
- RdData, out, CNT_W: registered snapshot readout.
- SnapValid, out, 1: one-cycle pulse when a new snapshot is visible.
- CycleCnt, out, CNT_W: live cycle counter.
- Overflow, out, NUM_CH+1: sticky overflow flags; bits [NUM_CH-1:0] are the channels, bit NUM_CH is the cycle counter.

## Operation
- Live state: cycle counter, NUM_CH event counters, period counter (0..PERIOD-1), Overflow flags, snapshot bank (NUM_CH+1 entries).
- Cycle counter: increments when En=1.
- Channel i: increments when En=1 and Event[i]=1.
- Overflow, SAT=0: an increment at 2^CNT_W-1 gives 0 and sets the Overflow bit.
- Overflow, SAT=1: an increment at 2^CNT_W-1 holds the value and sets the Overflow bit.
- Overflow bits stay set until Clear or Reset.
- Period counter: increments when En=1 and wraps at PERIOD-1 to 0.
- The cycle where En=1 and the period counter is at PERIOD-1 is the snapshot cycle. On that edge each snapshot entry loads its counter's next value, so it includes the snapshot cycle's increment.
- Clear=1 on an edge zeroes the cycle, event and period counters and Overflow. Snapshots are retained.
- Clear has priority over increments and suppresses the snapshot on that edge.
- RdData is registered from snapshot[RdSel] every cycle. An RdSel value above NUM_CH reads 0.
- Boundary case, En=0: nothing changes except RdData tracking RdSel.
- Boundary case, same-cycle Event and Clear: the counter becomes 0.
- Boundary case, PERIOD wraps while a counter overflows: the snapshot holds the post-overflow value (0 or max) and Overflow is set.

## Timing
- Reset (asynchronous assert) sets every output to 0: RdData, SnapValid, CycleCnt, Overflow. All counters, the period counter and all snapshot entries are also 0.
- Reset release: the first counting edge is the first rising edge after deassertion with En=1.
- Counter latency: Event at edge k is visible in the count after edge k.
- Snapshot: written on edge k, the snapshot cycle. SnapValid is high for the cycle after edge k only.
- RdData latency: shows new snapshot data after edge k+1, i.e. one cycle after RdSel or the snapshot changes.
- Back-to-back: with PERIOD=2 and En always 1, SnapValid pulses every second cycle.
- Reset asserted mid-period aborts the period. No partial snapshot is written.

## Structure
- Shared package perf_pkg holds:
  - the SAT mode constants (PERF_WRAP=0, PERF_SAT=1);
  - the RdSel encoding for the cycle-count entry.
- One sub-module, perf_counter_cell, is instantiated NUM_CH+1 times (including the cycle counter).
  - Parameters: CNT_W, SAT.
  - Inputs: Clock, Reset, Inc, Clear.
  - Outputs: Count, Next, Ovf.
- The top module holds the period counter, snapshot bank, read mux and SnapValid.

## Test plan
- Reset state: NUM_CH=4, PERIOD=10. Hold Reset low, then release with En=1 and Event=4'b0001 for 10 cycles.
  - SnapValid pulses once on cycle 11.
  - RdSel=0 reads 10; RdSel=4 reads 10; RdSel=1 reads 0.
- Gating: En toggles 1/0 for 20 cycles with Event=4'b1111 throughout, PERIOD=10.
  - The first snapshot occurs after 20 cycles, with every channel at 10.
- Wrap mode: CNT_W=8, SAT=0, Event[2]=1 for 257 enabled cycles.
  - Channel 2 reads 1 and Overflow[2]=1.
  - After Clear=1 for one cycle, channel 2 and Overflow both read 0.
- Saturate mode: same stimulus as the wrap test with SAT=1.
  - Channel 2 stays at 255 and Overflow[2]=1.
- Clear collision: Clear=1 exactly on the snapshot cycle.
  - No SnapValid pulse; the previous snapshot values are retained.
  - The next snapshot arrives PERIOD cycles later.
- Asynchronous reset mid-run: assert Reset low between edges at cycle 5 of a period.
  - All outputs are 0 immediately, before the next edge.
  - No SnapValid pulse follows.
